// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: external data-memory port (req/gnt/rvalid handshake).
// master = access controller, slave = memory.
interface dm_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    modport master (
        output ext_req,
        output ext_we,
        output ext_addr,
        output ext_wdata,
        input  ext_gnt,
        input  ext_rvalid,
        input  ext_rdata
    );

    modport slave (
        input  ext_req,
        input  ext_we,
        input  ext_addr,
        input  ext_wdata,
        output ext_gnt,
        output ext_rvalid,
        output ext_rdata
    );
endinterface

// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data-memory access controller driving the dst-mux load data.
// Optional watchdog timer enabled by defining DM_TIMEOUT_EN.
module dm_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] mem_data,
    output logic              stall,
    output logic              err,
    dm_ctrl_if.master         ext
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       acc;
    logic       tmo;

    assign acc = dm_re | dm_we;

`ifdef DM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    // Fires on the TIMEOUT-th cycle spent in REQ+WAIT.
    assign tmo = ((state == S_REQ) || (state == S_WAIT)) &&
                 (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == S_IDLE) begin
            timer <= '0;
        end else if ((state == S_REQ) || (state == S_WAIT)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= tmo && !((state == S_REQ) && ext.ext_gnt)
                       && !((state == S_WAIT) && ext.ext_rvalid);
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (acc) state_nxt = S_REQ;
            end
            (state == S_REQ): begin
                if (ext.ext_gnt) state_nxt = ext.ext_we ? S_DONE : S_WAIT;
                else if (tmo)    state_nxt = S_DONE;
            end
            (state == S_WAIT): begin
                if (ext.ext_rvalid || tmo) state_nxt = S_DONE;
            end
            (state == S_DONE): begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stall = ((state == S_IDLE) && acc) ||
                   (state == S_REQ) || (state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ext.ext_req   <= 1'b0;
            ext.ext_we    <= 1'b0;
            ext.ext_addr  <= '0;
            ext.ext_wdata <= '0;
            mem_data      <= '0;
        end else begin
            state <= state_nxt;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (acc) begin
                        ext.ext_req   <= 1'b1;
                        ext.ext_we    <= dm_we;
                        ext.ext_addr  <= addr;
                        ext.ext_wdata <= wr_data;
                    end
                end
                (state == S_REQ): begin
                    if (ext.ext_gnt) begin
                        ext.ext_req <= 1'b0;
                    end else if (tmo) begin
                        ext.ext_req <= 1'b0;
                        if (!ext.ext_we) mem_data <= '0;
                    end
                end
                (state == S_WAIT): begin
                    if (ext.ext_rvalid) mem_data <= ext.ext_rdata;
                    else if (tmo)       mem_data <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed scoreboard bench for dm_ctrl.
// Build with DM_TIMEOUT_EN defined to also cover the watchdog.
module tb_dm_ctrl;
    logic        clk;
    logic        rst;
    logic        dm_re;
    logic        dm_we;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] mem_data;
    logic        stall;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = '0;

    dm_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dm_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .addr     (addr),
        .wr_data  (wr_data),
        .mem_data (mem_data),
        .stall    (stall),
        .err      (err),
        .ext      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One access with gnt after gd extra REQ cycles, rvalid after rd extra WAIT cycles.
    task automatic access(input logic re, input logic we,
                          input logic [31:0] a, input logic [31:0] d,
                          input int gd, input int rd, input logic [31:0] rdat,
                          output int req_cyc, output int done_cyc);
        logic        ld;
        logic [31:0] want;
        ld      = !we;
        dm_re   = re;
        dm_we   = we;
        addr    = a;
        wr_data = d;
        if (ld) exp_q.push_back(rdat);
        #1 chk("stall_idle", stall, 1);
        @(negedge clk);
        req_cyc = cyc;
        chk("ext_we", bus.ext_we, we);
        chk("ext_addr", bus.ext_addr, a);
        if (we) chk("ext_wdata", bus.ext_wdata, d);
        for (int i = 0; i <= gd; i++) begin
            chk("ext_req_hi", bus.ext_req, 1);
            chk("stall_req", stall, 1);
            bus.ext_gnt    = (i == gd);
            bus.ext_rvalid = (i < gd);
            bus.ext_rdata  = 32'h5EED_0000 | i;
            @(negedge clk);
        end
        bus.ext_gnt = 1'b0;
        if (ld) begin
            for (int i = 0; i <= rd; i++) begin
                chk("ext_req_lo", bus.ext_req, 0);
                chk("stall_wait", stall, 1);
                chk("mem_hold_wait", mem_data, last_ld);
                bus.ext_rvalid = (i == rd);
                bus.ext_rdata  = (i == rd) ? rdat : (32'hBAD0_0000 | i);
                @(negedge clk);
            end
        end
        bus.ext_rvalid = 1'b0;
        done_cyc = cyc;
        chk("stall_done", stall, 0);
        chk("ext_req_done", bus.ext_req, 0);
        chk("err_done", err, 0);
        if (ld) begin
            want    = exp_q.pop_front();
            last_ld = want;
        end
        chk("mem_data_done", mem_data, last_ld);
        dm_re = 1'b0;
        dm_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int rq;
        int dn;
        int rq2;
        int dn2;
        int n;
        int k;
        rst            = 1'b1;
        dm_re          = 1'b0;
        dm_we          = 1'b0;
        addr           = '0;
        wr_data        = '0;
        bus.ext_gnt    = 1'b0;
        bus.ext_rvalid = 1'b0;
        bus.ext_rdata  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", bus.ext_req, 0);
        chk("rst_we", bus.ext_we, 0);
        chk("rst_addr", bus.ext_addr, 0);
        chk("rst_wdata", bus.ext_wdata, 0);
        chk("rst_mem", mem_data, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);

        // Load with immediate gnt/rvalid: 3 stalled cycles
        access(1, 0, 32'h100, 32'h0, 0, 0, 32'hCAFE_F00D, rq, dn);
        chk("t1_latency", dn - rq, 2);
        chk("t1_hold_mem", mem_data, 32'hCAFE_F00D);
        chk("t1_hold_stall", stall, 0);

        // Store with gnt delayed 4 cycles, stray rvalid during REQ
        access(0, 1, 32'h200, 32'h1234_5678, 4, 0, 32'h0, rq, dn);
        chk("t2_latency", dn - rq, 5);

        // Both requests set: store wins
        access(1, 1, 32'h300, 32'hAAAA_5555, 1, 0, 32'h0, rq, dn);
        chk("t3_latency", dn - rq, 2);

        // Reset during WAIT
        dm_re = 1'b1;
        addr  = 32'h400;
        @(negedge clk);
        chk("t4_req", bus.ext_req, 1);
        bus.ext_gnt = 1'b1;
        @(negedge clk);
        bus.ext_gnt = 1'b0;
        chk("t4_wait_stall", stall, 1);
        chk("t4_wait_req", bus.ext_req, 0);
        rst = 1'b1;
        #1;
        chk("t4_rst_req", bus.ext_req, 0);
        chk("t4_rst_mem", mem_data, 0);
        chk("t4_rst_stall_re", stall, 1);
        dm_re = 1'b0;
        #1 chk("t4_rst_stall", stall, 0);
        @(negedge clk);
        rst            = 1'b0;
        bus.ext_rvalid = 1'b1;
        bus.ext_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.ext_rvalid = 1'b0;
        chk("t4_late_mem", mem_data, 0);
        chk("t4_late_stall", stall, 0);
        chk("t4_late_req", bus.ext_req, 0);
        last_ld = '0;

        // Back-to-back loads
        access(1, 0, 32'hA, 32'h0, 0, 0, 32'hA, rq, dn);
        access(1, 0, 32'hB, 32'h0, 1, 2, 32'hB, rq2, dn2);
        chk("t5_gap", rq2 - dn, 2);
        chk("t5_mem", mem_data, 32'hB);

`ifdef DM_TIMEOUT_EN
        // Watchdog: gnt never arrives
        dm_re = 1'b1;
        addr  = 32'h600;
        #1 chk("t6_stall0", stall, 1);
        @(negedge clk);
        n = 0;
        k = 0;
        while (stall && k < 50) begin
            if (bus.ext_req) n++;
            k++;
            @(negedge clk);
        end
        chk("t6_req_cycles", n, 8);
        chk("t6_err", err, 1);
        chk("t6_mem", mem_data, 0);
        chk("t6_stall", stall, 0);
        chk("t6_req_lo", bus.ext_req, 0);
        dm_re = 1'b0;
        @(negedge clk);
        chk("t6_err_pulse", err, 0);
        last_ld = '0;
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
